// File: rtl/bram_to_axis_if.sv
`default_nettype none
// ============================================================================
//  Module      : bram_to_axis_if
//  Description : AXI4-Stream bundle for the bram_to_axis read streamer.
//                master modport : drives tdata/tvalid/tlast, samples tready
//                slave  modport : samples tdata/tvalid/tlast, drives tready
//  Revision    : 1.0 - initial release
// ============================================================================
interface bram_to_axis_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/bram_to_axis.sv
`default_nettype none
// ============================================================================
//  Module      : bram_to_axis
//  Description : Streams a block of BRAM words onto an AXI4-Stream master.
//                A start pulse in IDLE captures base_addr/length; reads are
//                issued under a 4-credit rule into a 4-entry prefetch FIFO
//                whose head drives the stream. TLAST marks the final beat and
//                done pulses once the burst completes.
//
//  Ports       : ACLK, ARESETN (async active-low)
//                start, base_addr, length   - burst request
//                busy, done                 - burst status
//                bram_en, bram_addr, bram_dout - BRAM read port
//                m_axis (bram_to_axis_if.master) - output stream
//
//  Macro       : BRAM_TO_AXIS_OREG_EN - BRAM output register in use, read
//                latency 2 instead of 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_to_axis #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  wire logic                  ACLK,
    input  wire logic                  ARESETN,
    input  wire logic                  start,
    input  wire logic [ADDR_WIDTH-1:0] base_addr,
    input  wire logic [LEN_WIDTH-1:0]  length,
    output logic                       busy,
    output logic                       done,
    output logic                       bram_en,
    output logic [ADDR_WIDTH-1:0]      bram_addr,
    input  wire logic [DATA_WIDTH-1:0] bram_dout,
    bram_to_axis_if.master             m_axis
);

`ifdef BRAM_TO_AXIS_OREG_EN
    localparam int c_LAT = 2;
`else
    localparam int c_LAT = 1;
`endif
    localparam logic [2:0] c_CREDITS = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_zero;     // current request had length 0
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_issued;
    logic [LEN_WIDTH-1:0]  r_beats;

    // One bit per outstanding read; bit c_LAT-1 marks data valid on bram_dout
    logic [c_LAT-1:0]      r_rd_pipe;

    logic [DATA_WIDTH-1:0] r_fifo [4];
    logic [1:0]            r_wptr;
    logic [1:0]            r_rptr;
    logic [2:0]            r_count;

    logic [2:0]            w_inflight;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_tvalid;
    logic                  w_last;

    always_comb begin
        w_inflight = 3'd0;
        for (int i = 0; i < c_LAT; i++) begin
            w_inflight = w_inflight + 3'(r_rd_pipe[i]);
        end
    end

    // Reads in flight plus buffered words never exceed the FIFO depth, so a
    // returning word always finds a free slot.
    assign w_issue  = (r_state == S_RUN) && ((w_inflight + r_count) < c_CREDITS);
    assign w_push   = r_rd_pipe[c_LAT-1];
    assign w_tvalid = (r_count != 3'd0);
    assign w_pop    = w_tvalid && m_axis.tready;
    assign w_last   = (r_beats == (r_len - LEN_WIDTH'(1)));

    assign bram_en       = w_issue;
    assign bram_addr     = r_addr;
    assign busy          = r_busy;
    assign done          = r_done;
    assign m_axis.tvalid = w_tvalid;
    assign m_axis.tdata  = r_fifo[r_rptr];
    assign m_axis.tlast  = w_tvalid && w_last;

    // ------------------------------------------------------------------
    // Read-return tracking and prefetch FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rd_pipe <= '0;
            r_wptr    <= 2'd0;
            r_rptr    <= 2'd0;
            r_count   <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            r_rd_pipe <= c_LAT'({r_rd_pipe, w_issue});
            if (w_push) begin
                r_fifo[r_wptr] <= bram_dout;
                r_wptr         <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_zero   <= 1'b0;
            r_addr   <= '0;
            r_len    <= '0;
            r_issued <= '0;
            r_beats  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_pop) begin
                r_beats <= r_beats + LEN_WIDTH'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr   <= base_addr;
                        r_len    <= length;
                        r_issued <= '0;
                        r_beats  <= '0;
                        if (length == '0) begin
                            r_zero  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_zero  <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    if (w_issue) begin
                        r_addr   <= r_addr + ADDR_WIDTH'(1);
                        r_issued <= r_issued + LEN_WIDTH'(1);
                        if ((r_issued + LEN_WIDTH'(1)) == r_len) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    // The final handshake closes the burst; done is visible
                    // in the very next cycle.
                    if (w_pop && w_last) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_FIN;
                    end
                end

                S_FIN: begin
                    // A zero-length request reaches FIN straight from IDLE, so
                    // its done pulse is raised here, one cycle later.
                    if (r_zero) begin
                        r_done <= 1'b1;
                    end
                    r_zero  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_to_axis.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_to_axis
//  Description : Self-checking bench for bram_to_axis. Stimulus pushes the
//                expected beats into a queue; a monitor pops and compares on
//                every stream handshake and checks stability while stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_to_axis;

`ifdef BRAM_TO_AXIS_OREG_EN
    localparam int c_LAT = 2;
`else
    localparam int c_LAT = 1;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic        tb_ACLK;
    logic        ARESETN;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic        busy;
    logic        done;
    logic        bram_en;
    logic [9:0]  bram_addr;
    logic [31:0] bram_dout;

    bram_to_axis_if #(.DATA_WIDTH(32)) axis ();

    bram_to_axis #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(10),
        .LEN_WIDTH (11)
    ) dut (
        .ACLK     (tb_ACLK),
        .ARESETN  (ARESETN),
        .start    (start),
        .base_addr(base_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .bram_en  (bram_en),
        .bram_addr(bram_addr),
        .bram_dout(bram_dout),
        .m_axis   (axis)
    );

    // ---------------- BRAM model ----------------
    logic [31:0] mem [1024];
    logic [31:0] r_ram_q;
    logic [31:0] r_ram_q2;

    always @(posedge tb_ACLK) begin
        if (bram_en) r_ram_q <= mem[bram_addr];
        r_ram_q2 <= r_ram_q;
    end
`ifdef BRAM_TO_AXIS_OREG_EN
    assign bram_dout = r_ram_q2;
`else
    assign bram_dout = r_ram_q;
`endif

    initial tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Scoreboard monitor ----------------
    logic        stall_prev = 1'b0;
    logic [31:0] held_data;
    logic        held_last;

    always @(negedge tb_ACLK) begin
        if (ARESETN === 1'b1) begin
            if (stall_prev) begin
                check("stall_hold", {31'd0, axis.tvalid, axis.tlast, axis.tdata},
                      {31'd0, 1'b1, held_last, held_data});
            end
            if (axis.tvalid && axis.tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {31'd0, axis.tlast, axis.tdata}, 64'd0 - 64'd1);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat", {31'd0, axis.tlast, axis.tdata}, {31'd0, e.l, e.d});
                end
            end
            stall_prev = axis.tvalid && !axis.tready;
            held_data  = axis.tdata;
            held_last  = axis.tlast;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic push_beat(input logic [31:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        exp_q.push_back(b);
    endtask

    // Runs one request; mode 0 = tready high, mode 1 = tready 1,0,0,1 cycling.
    task automatic run_burst(input logic [9:0] b, input logic [10:0] n,
                             input int mode, input bit extra_start);
        int         c;
        int         first_tv;
        int         done_c;
        int         last_hs;
        int         n_en;
        int         n_hs;
        int         max_out;
        logic       busy_at_done;
        logic [9:0] exp_addr;

        axis.tready = 1'b1;
        repeat (2) @(posedge tb_ACLK);
        #1;
        start     = 1'b1;
        base_addr = b;
        length    = n;
        @(posedge tb_ACLK);
        #1;
        start        = 1'b0;
        c            = 1;
        first_tv     = -1;
        done_c       = -1;
        last_hs      = -1;
        n_en         = 0;
        n_hs         = 0;
        max_out      = 0;
        busy_at_done = 1'b1;
        exp_addr     = b;
        while (done_c < 0 && c < 400) begin
            if (mode == 1) axis.tready = (((c - 1) % 4) == 0) || (((c - 1) % 4) == 3);
            else           axis.tready = 1'b1;
            if (extra_start && c == 5) begin
                start     = 1'b1;
                base_addr = 10'h100;
                length    = 11'd2;
            end else begin
                start = 1'b0;
            end
            if (c == 1) begin
                check("cycle1_busy_en", {62'd0, busy, bram_en}, (n != 0) ? 64'd3 : 64'd0);
            end
            if (bram_en) begin
                check("bram_addr", {54'd0, bram_addr}, {54'd0, exp_addr});
                exp_addr = exp_addr + 10'd1;
                n_en++;
            end
            if ((n_en - n_hs) > max_out) max_out = n_en - n_hs;
            if (axis.tvalid && first_tv < 0) first_tv = c;
            if (axis.tvalid && axis.tready) begin
                n_hs++;
                if (axis.tlast) last_hs = c;
            end
            if (done) begin
                done_c       = c;
                busy_at_done = busy;
            end else begin
                @(posedge tb_ACLK);
                #1;
                c++;
            end
        end
        start = 1'b0;
        if (done_c < 0) begin
            check("done_timeout", 64'd0, 64'd1);
        end else if (n == 0) begin
            check("zero_done_cycle", 64'(done_c), 64'd2);
            check("zero_no_en_tvalid", {32'(n_en), 32'(first_tv)}, {32'd0, 32'hFFFF_FFFF});
        end else begin
            check("first_tvalid_cycle", 64'(first_tv), 64'(2 + c_LAT));
            check("done_after_last", 64'(done_c), 64'(last_hs + 1));
            check("busy_low_at_done", {63'd0, busy_at_done}, 64'd0);
            check("read_count", 64'(n_en), 64'(n));
            check("max_outstanding_le4", {63'd0, (max_out <= 4)}, 64'd1);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h5A00_0000 | 32'(i);
        mem[0]       = 32'h0101_FFFF;
        mem[1]       = 32'hABCD_0001;
        mem[2]       = 32'hDEAD_0011;
        mem[3]       = 32'hBEEF_0011;
        mem[10'h3FE] = 32'hC0DE_03FE;
        mem[10'h3FF] = 32'hC0DE_03FF;

        ARESETN     = 1'b0;
        start       = 1'b0;
        base_addr   = '0;
        length      = '0;
        axis.tready = 1'b1;
        repeat (3) @(posedge tb_ACLK);
        #1;
        check("reset_outputs", {17'd0, busy, done, bram_en, bram_addr, axis.tvalid, axis.tdata, axis.tlast}, 64'd0);
        ARESETN = 1'b1;

        // Basic burst, tready high
        push_beat(32'h0101_FFFF, 1'b0);
        push_beat(32'hABCD_0001, 1'b0);
        push_beat(32'hDEAD_0011, 1'b0);
        push_beat(32'hBEEF_0011, 1'b1);
        run_burst(10'h000, 11'd4, 0, 1'b0);

        // Same burst under backpressure
        push_beat(32'h0101_FFFF, 1'b0);
        push_beat(32'hABCD_0001, 1'b0);
        push_beat(32'hDEAD_0011, 1'b0);
        push_beat(32'hBEEF_0011, 1'b1);
        run_burst(10'h000, 11'd4, 1, 1'b0);

        // Address wrap
        push_beat(32'hC0DE_03FE, 1'b0);
        push_beat(32'hC0DE_03FF, 1'b0);
        push_beat(32'h0101_FFFF, 1'b0);
        push_beat(32'hABCD_0001, 1'b1);
        run_burst(10'h3FE, 11'd4, 0, 1'b0);

        // Zero length
        run_burst(10'h000, 11'd0, 0, 1'b0);

        // len=8 with a second start while busy (must be ignored)
        for (int i = 0; i < 8; i++) push_beat(mem[i], (i == 7));
        run_burst(10'h000, 11'd8, 0, 1'b1);
        begin
            int extra_tv;
            extra_tv = 0;
            repeat (10) begin
                @(posedge tb_ACLK);
                #1;
                if (axis.tvalid || busy || bram_en) extra_tv++;
            end
            check("ignored_start_idle", 64'(extra_tv), 64'd0);
        end

        // Reset mid-burst after two beats
        for (int i = 0; i < 8; i++) push_beat(mem[i], (i == 7));
        start     = 1'b1;
        base_addr = 10'h000;
        length    = 11'd8;
        @(posedge tb_ACLK);
        #1;
        start = 1'b0;
        begin
            int hs;
            int guard;
            hs    = 0;
            guard = 0;
            while (hs < 2 && guard < 50) begin
                if (axis.tvalid && axis.tready) hs++;
                if (hs < 2) begin
                    @(posedge tb_ACLK);
                    #1;
                end
                guard++;
            end
            check("reset_test_two_beats", 64'(hs), 64'd2);
        end
        @(posedge tb_ACLK);
        #3;
        ARESETN = 1'b0;
        #1;
        check("async_reset_outputs", {17'd0, busy, done, bram_en, bram_addr, axis.tvalid, axis.tdata, axis.tlast}, 64'd0);
        exp_q.delete();
        begin
            int done_seen;
            done_seen = 0;
            repeat (3) begin
                @(posedge tb_ACLK);
                #1;
                if (done) done_seen++;
            end
            ARESETN = 1'b1;
            repeat (4) begin
                @(posedge tb_ACLK);
                #1;
                if (done || busy || axis.tvalid) done_seen++;
            end
            check("no_done_after_abort", 64'(done_seen), 64'd0);
        end

        // Clean burst after reset
        push_beat(mem[4], 1'b0);
        push_beat(mem[5], 1'b0);
        push_beat(mem[6], 1'b1);
        run_burst(10'h004, 11'd3, 0, 1'b0);

        repeat (3) @(posedge tb_ACLK);
        #1;
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
